// File: rtl/readout_rx_pkg.sv
// Shared definitions for the readout RX classifier controller: FSM states,
// host table field selects and classifier coefficient addresses.
package readout_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_INT,
        LOAD_SLOPE,
        START,
        STREAM,
        DRAIN,
        REPORT
    } state_e;

    localparam logic [1:0] SEL_INTERCEPT = 2'd0;
    localparam logic [1:0] SEL_SLOPE     = 2'd1;
    localparam logic [1:0] SEL_THRESHOLD = 2'd2;

    localparam logic COEFF_ADDR_INTERCEPT = 1'b0;
    localparam logic COEFF_ADDR_SLOPE     = 1'b1;

endpackage

// File: rtl/readout_rx_coeff_table.sv
// Per-qubit {y_intercept, slope, threshold} register file. The host write
// port may fire at any time; the read port is a combinational lookup by qid.
// Ids at or beyond NUM_QUBITS are ignored on write and read back as zero.
module readout_rx_coeff_table
    import readout_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_QUBITS  = 4,
    parameter int QID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [QID_WIDTH-1:0]   wr_qid,
    input  logic [1:0]             wr_sel,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [QID_WIDTH-1:0]   rd_qid,
    output logic [DATA_WIDTH-1:0]  rd_intercept,
    output logic [DATA_WIDTH-1:0]  rd_slope,
    output logic [COUNT_WIDTH-1:0] rd_threshold
);

    logic [DATA_WIDTH-1:0]  intercept_q [NUM_QUBITS];
    logic [DATA_WIDTH-1:0]  intercept_d [NUM_QUBITS];
    logic [DATA_WIDTH-1:0]  slope_q     [NUM_QUBITS];
    logic [DATA_WIDTH-1:0]  slope_d     [NUM_QUBITS];
    logic [COUNT_WIDTH-1:0] threshold_q [NUM_QUBITS];
    logic [COUNT_WIDTH-1:0] threshold_d [NUM_QUBITS];

    // Apply a host write to the selected field of the addressed entry.
    always_comb begin
        intercept_d = intercept_q;
        slope_d     = slope_q;
        threshold_d = threshold_q;
        for (int i = 0; i < NUM_QUBITS; i++) begin
            if (wr_en && (wr_qid == QID_WIDTH'(i))) begin
                case (wr_sel)
                    SEL_INTERCEPT: intercept_d[i] = wr_data;
                    SEL_SLOPE:     slope_d[i]     = wr_data;
                    SEL_THRESHOLD: threshold_d[i] = wr_data[COUNT_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Table storage, cleared to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_QUBITS; i++) begin
                intercept_q[i] <= '0;
                slope_q[i]     <= '0;
                threshold_q[i] <= '0;
            end
        end else begin
            intercept_q <= intercept_d;
            slope_q     <= slope_d;
            threshold_q <= threshold_d;
        end
    end

    // Combinational lookup of the entry selected by rd_qid.
    always_comb begin
        rd_intercept = '0;
        rd_slope     = '0;
        rd_threshold = '0;
        for (int i = 0; i < NUM_QUBITS; i++) begin
            if (rd_qid == QID_WIDTH'(i)) begin
                rd_intercept = intercept_q[i];
                rd_slope     = slope_q[i];
                rd_threshold = threshold_q[i];
            end
        end
    end

endmodule

// File: rtl/readout_rx_classifier_ctrl.sv
// Time-multiplexes one linear-boundary classifier across several qubits:
// loads the qubit's coefficients, frames a window of IQ samples, counts the
// |1> decisions (including those still in the classifier pipeline) and
// reports a thresholded single-shot state.
module readout_rx_classifier_ctrl
    import readout_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_QUBITS    = 4,
    parameter int QID_WIDTH     = 2,
    parameter int NUM_SAMPLES   = 256,
    parameter int COUNT_WIDTH   = 9,
    parameter int DRAIN_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tbl_wr_en,
    input  logic [QID_WIDTH-1:0]   tbl_wr_qid,
    input  logic [1:0]             tbl_wr_sel,
    input  logic [DATA_WIDTH-1:0]  tbl_wr_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [QID_WIDTH-1:0]   req_qid,
    input  logic                   smp_valid,
    output logic                   smp_ready,
    input  logic [DATA_WIDTH-1:0]  smp_i,
    input  logic [DATA_WIDTH-1:0]  smp_q,
    output logic                   cls_coeff_wr_en,
    output logic                   cls_coeff_wr_addr,
    output logic [DATA_WIDTH-1:0]  cls_coeff_wr_data,
    output logic                   cls_start_count,
    output logic                   cls_finish_count,
    output logic                   cls_valid,
    output logic [DATA_WIDTH-1:0]  cls_i,
    output logic [DATA_WIDTH-1:0]  cls_q,
    input  logic                   cls_valid_out,
    input  logic                   cls_finish_out,
    input  logic                   cls_count_condition,
    output logic                   res_valid,
    output logic [QID_WIDTH-1:0]   res_qid,
    output logic                   res_state,
    output logic [COUNT_WIDTH-1:0] res_count,
    output logic                   res_err
);

    localparam int TIMER_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [QID_WIDTH:0]     NUM_QUBITS_EXT = (QID_WIDTH + 1)'(NUM_QUBITS);
    localparam logic [COUNT_WIDTH-1:0] LAST_SAMPLE    = COUNT_WIDTH'(NUM_SAMPLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX      = '1;
    localparam logic [TIMER_W-1:0]     TIMER_LAST     = TIMER_W'(DRAIN_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [QID_WIDTH-1:0]   qid_q, qid_d;
    logic [COUNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
    logic [COUNT_WIDTH-1:0] ones_q, ones_d;
    logic [COUNT_WIDTH-1:0] thr_q, thr_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [QID_WIDTH-1:0]   res_qid_q, res_qid_d;
    logic                   res_state_q, res_state_d;
    logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
    logic                   res_err_q, res_err_d;

    logic [DATA_WIDTH-1:0]  rd_intercept;
    logic [DATA_WIDTH-1:0]  rd_slope;
    logic [COUNT_WIDTH-1:0] rd_threshold;

    logic                   req_hs;
    logic                   qid_bad;
    logic                   smp_hs;
    logic                   last_smp;
    logic                   drain_done;
    logic                   drain_timeout;
    logic                   ones_inc;
    logic [COUNT_WIDTH-1:0] ones_next;

    readout_rx_coeff_table #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_QUBITS  (NUM_QUBITS),
        .QID_WIDTH   (QID_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (tbl_wr_en),
        .wr_qid       (tbl_wr_qid),
        .wr_sel       (tbl_wr_sel),
        .wr_data      (tbl_wr_data),
        .rd_qid       (qid_q),
        .rd_intercept (rd_intercept),
        .rd_slope     (rd_slope),
        .rd_threshold (rd_threshold)
    );

    assign req_hs        = (state_q == IDLE) && req_valid;
    assign qid_bad       = {1'b0, req_qid} >= NUM_QUBITS_EXT;
    assign smp_hs        = (state_q == STREAM) && smp_valid;
    assign last_smp      = smp_hs && (smp_cnt_q == LAST_SAMPLE);
    assign drain_done    = (state_q == DRAIN) && cls_valid_out && cls_finish_out;
    assign drain_timeout = (state_q == DRAIN) && !drain_done && (timer_q == TIMER_LAST);
    assign ones_inc      = ((state_q == STREAM) || (state_q == DRAIN)) &&
                           cls_valid_out && cls_count_condition;
    assign ones_next     = (ones_inc && (ones_q != COUNT_MAX)) ? ones_q + 1'b1 : ones_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (req_hs) state_d = qid_bad ? REPORT : LOAD_INT;
            LOAD_INT:   state_d = LOAD_SLOPE;
            LOAD_SLOPE: state_d = START;
            START:      state_d = STREAM;
            STREAM:     if (last_smp) state_d = DRAIN;
            DRAIN:      if (drain_done || drain_timeout) state_d = REPORT;
            REPORT:     state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next values: request latch, counters, captured threshold, result.
    always_comb begin
        qid_d       = qid_q;
        smp_cnt_d   = smp_cnt_q;
        ones_d      = ones_q;
        thr_d       = thr_q;
        timer_d     = timer_q;
        res_qid_d   = res_qid_q;
        res_state_d = res_state_q;
        res_count_d = res_count_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    qid_d     = req_qid;
                    smp_cnt_d = '0;
                    ones_d    = '0;
                    timer_d   = '0;
                    if (qid_bad) begin
                        res_qid_d   = req_qid;
                        res_state_d = 1'b0;
                        res_count_d = '0;
                        res_err_d   = 1'b1;
                    end
                end
            end
            LOAD_INT: thr_d = rd_threshold;
            STREAM: begin
                ones_d  = ones_next;
                timer_d = '0;
                if (smp_hs) smp_cnt_d = smp_cnt_q + 1'b1;
            end
            DRAIN: begin
                ones_d  = ones_next;
                timer_d = timer_q + 1'b1;
                if (drain_done || drain_timeout) begin
                    res_qid_d   = qid_q;
                    res_count_d = ones_next;
                    res_state_d = (ones_next >= thr_q);
                    res_err_d   = drain_timeout;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qid_q       <= '0;
            smp_cnt_q   <= '0;
            ones_q      <= '0;
            thr_q       <= '0;
            timer_q     <= '0;
            res_qid_q   <= '0;
            res_state_q <= 1'b0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            qid_q       <= qid_d;
            smp_cnt_q   <= smp_cnt_d;
            ones_q      <= ones_d;
            thr_q       <= thr_d;
            timer_q     <= timer_d;
            res_qid_q   <= res_qid_d;
            res_state_q <= res_state_d;
            res_count_q <= res_count_d;
            res_err_q   <= res_err_d;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        req_ready         = (state_q == IDLE);
        smp_ready         = (state_q == STREAM);
        cls_coeff_wr_en   = (state_q == LOAD_INT) || (state_q == LOAD_SLOPE);
        cls_coeff_wr_addr = (state_q == LOAD_SLOPE) ? COEFF_ADDR_SLOPE : COEFF_ADDR_INTERCEPT;
        cls_coeff_wr_data = '0;
        if (state_q == LOAD_INT)   cls_coeff_wr_data = rd_intercept;
        if (state_q == LOAD_SLOPE) cls_coeff_wr_data = rd_slope;
        cls_start_count   = (state_q == START);
        cls_finish_count  = last_smp;
        cls_valid         = smp_hs;
        cls_i             = (state_q == STREAM) ? smp_i : '0;
        cls_q             = (state_q == STREAM) ? smp_q : '0;
        res_valid         = (state_q == REPORT);
        res_qid           = res_qid_q;
        res_state         = res_state_q;
        res_count         = res_count_q;
        res_err           = res_err_q;
    end

endmodule

// File: tb/tb_readout_rx_classifier_ctrl.sv
// Self-checking bench for readout_rx_classifier_ctrl. A small 2-cycle
// classifier model flags samples with i > q as |1>; expected results are
// queued when a request is issued and checked by a separate monitor.
module tb_readout_rx_classifier_ctrl;

    localparam int DW = 16;
    localparam int NQ = 4;
    localparam int QW = 3;
    localparam int NS = 256;
    localparam int CW = 9;
    localparam int DT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tbl_wr_en = 1'b0;
    logic [QW-1:0] tbl_wr_qid = '0;
    logic [1:0]    tbl_wr_sel = '0;
    logic [DW-1:0] tbl_wr_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [QW-1:0] req_qid = '0;
    logic          smp_valid = 1'b0;
    logic          smp_ready;
    logic [DW-1:0] smp_i = '0;
    logic [DW-1:0] smp_q = '0;
    logic          cls_coeff_wr_en;
    logic          cls_coeff_wr_addr;
    logic [DW-1:0] cls_coeff_wr_data;
    logic          cls_start_count;
    logic          cls_finish_count;
    logic          cls_valid;
    logic [DW-1:0] cls_i;
    logic [DW-1:0] cls_q;
    logic          cls_valid_out;
    logic          cls_finish_out;
    logic          cls_count_condition;
    logic          res_valid;
    logic [QW-1:0] res_qid;
    logic          res_state;
    logic [CW-1:0] res_count;
    logic          res_err;

    always #5 clk = ~clk;

    readout_rx_classifier_ctrl #(
        .DATA_WIDTH    (DW),
        .NUM_QUBITS    (NQ),
        .QID_WIDTH     (QW),
        .NUM_SAMPLES   (NS),
        .COUNT_WIDTH   (CW),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .tbl_wr_en           (tbl_wr_en),
        .tbl_wr_qid          (tbl_wr_qid),
        .tbl_wr_sel          (tbl_wr_sel),
        .tbl_wr_data         (tbl_wr_data),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_qid             (req_qid),
        .smp_valid           (smp_valid),
        .smp_ready           (smp_ready),
        .smp_i               (smp_i),
        .smp_q               (smp_q),
        .cls_coeff_wr_en     (cls_coeff_wr_en),
        .cls_coeff_wr_addr   (cls_coeff_wr_addr),
        .cls_coeff_wr_data   (cls_coeff_wr_data),
        .cls_start_count     (cls_start_count),
        .cls_finish_count    (cls_finish_count),
        .cls_valid           (cls_valid),
        .cls_i               (cls_i),
        .cls_q               (cls_q),
        .cls_valid_out       (cls_valid_out),
        .cls_finish_out      (cls_finish_out),
        .cls_count_condition (cls_count_condition),
        .res_valid           (res_valid),
        .res_qid             (res_qid),
        .res_state           (res_state),
        .res_count           (res_count),
        .res_err             (res_err)
    );

    typedef struct {
        logic [QW-1:0] qid;
        logic          state;
        logic [CW-1:0] count;
        logic          err;
        int            nValid;
        int            nStart;
        bit            chkLat;
    } exp_t;

    typedef struct {
        logic          addr;
        logic [DW-1:0] data;
    } coef_t;

    exp_t  expQ[$];
    coef_t coefQ[$];

    logic [DW-1:0] mInt   [NQ];
    logic [DW-1:0] mSlope [NQ];
    logic [CW-1:0] mThr   [NQ];

    int compared = 0;
    int mismatched = 0;
    int resultsSeen = 0;
    bit noFinish = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-cycle classifier model: decision is i > q (signed), finish follows the marker.
    logic [2:0] pipe1, pipe2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe1 <= '0;
            pipe2 <= '0;
        end else begin
            pipe1 <= {cls_valid, cls_finish_count && !noFinish,
                      cls_valid && ($signed(cls_i) > $signed(cls_q))};
            pipe2 <= pipe1;
        end
    end
    assign cls_valid_out       = pipe2[2];
    assign cls_finish_out      = pipe2[1];
    assign cls_count_condition = pipe2[0];

    // Monitor: samples on the falling edge and checks against the queued expectations.
    int    negCount = 0, hsNeg = 0, hsCount = 0, validCount = 0, startCount = 0;
    bit    busy = 1'b0, prevSlope = 1'b0;
    always @(negedge clk) begin
        exp_t  e;
        coef_t c;
        negCount++;
        if (!rst_n) begin
            busy = 0; prevSlope = 0; hsCount = 0; validCount = 0; startCount = 0;
        end else begin
            checkOutput("req_ready", req_ready, !busy);
            if (smp_valid && smp_ready) hsCount++;
            if (cls_valid) validCount++;
            if (cls_finish_count) begin
                checkOutput("finish_on_handshake", smp_valid && smp_ready, 1);
                checkOutput("finish_index", hsCount, NS);
            end
            if (prevSlope) checkOutput("start_after_slope", cls_start_count, 1);
            if (cls_start_count) startCount++;
            prevSlope = 0;
            if (cls_coeff_wr_en) begin
                checkOutput("coeff_wr_expected", coefQ.size() != 0, 1);
                if (coefQ.size() != 0) begin
                    c = coefQ.pop_front();
                    checkOutput("coeff_addr", cls_coeff_wr_addr, c.addr);
                    checkOutput("coeff_data", cls_coeff_wr_data, c.data);
                    prevSlope = (c.addr == 1'b1);
                end
            end
            if (res_valid) begin
                checkOutput("result_expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("res_qid", res_qid, e.qid);
                    checkOutput("res_state", res_state, e.state);
                    checkOutput("res_count", res_count, e.count);
                    checkOutput("res_err", res_err, e.err);
                    checkOutput("cls_valid_pulses", validCount, e.nValid);
                    checkOutput("start_pulses", startCount, e.nStart);
                    if (e.chkLat) checkOutput("err_report_latency", negCount - hsNeg, 1);
                end
                resultsSeen++;
                hsCount = 0; validCount = 0; startCount = 0; busy = 0;
            end
            if (req_valid && req_ready) begin
                busy  = 1;
                hsNeg = negCount;
            end
        end
    end

    task automatic writeTable(input logic [QW-1:0] qid, input logic [1:0] sel, input logic [DW-1:0] data);
        tbl_wr_en = 1; tbl_wr_qid = qid; tbl_wr_sel = sel; tbl_wr_data = data;
        tick();
        tbl_wr_en = 0;
        case (sel)
            2'd0: mInt[qid[1:0]]   = data;
            2'd1: mSlope[qid[1:0]] = data;
            2'd2: mThr[qid[1:0]]   = data[CW-1:0];
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic [QW-1:0] qid, input int nOnes, input bit gaps,
                                 input bit dropFinish, input bit abortMid, input bit rewriteThr);
        bit    flags [NS];
        int    start, n, iv, qv, j;
        bit    ok, tmp;
        exp_t  e;
        coef_t c;
        start = resultsSeen;
        for (int i = 0; i < NS; i++) flags[i] = (i < nOnes);
        for (int i = NS - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = flags[i]; flags[i] = flags[j]; flags[j] = tmp;
        end
        if (int'(qid) >= NQ) begin
            e.qid = qid; e.state = 0; e.count = '0; e.err = 1;
            e.nValid = 0; e.nStart = 0; e.chkLat = 1;
            expQ.push_back(e);
        end else begin
            c.addr = 0; c.data = mInt[qid[1:0]];   coefQ.push_back(c);
            c.addr = 1; c.data = mSlope[qid[1:0]]; coefQ.push_back(c);
            if (!abortMid) begin
                e.qid = qid; e.state = (nOnes >= int'(mThr[qid[1:0]]));
                e.count = CW'(nOnes); e.err = dropFinish;
                e.nValid = NS; e.nStart = 1; e.chkLat = 0;
                expQ.push_back(e);
            end
        end
        noFinish = dropFinish;
        req_qid = qid; req_valid = 1; n = 0; ok = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = req_ready; tick(); n++;
        end
        req_valid = 0;
        if (!ok) failNow("req_handshake_timeout");
        if (ok && int'(qid) < NQ) begin
            for (int k = 0; k < NS; k++) begin
                if (abortMid && k == 100) begin
                    smp_valid = 0;
                    rst_n = 0;
                    #1;
                    checkOutput("abort_req_ready", req_ready, 1);
                    checkOutput("abort_smp_ready", smp_ready, 0);
                    checkOutput("abort_res_valid", res_valid, 0);
                    for (int i = 0; i < NQ; i++) begin
                        mInt[i] = '0; mSlope[i] = '0; mThr[i] = '0;
                    end
                    tick(); tick();
                    rst_n = 1;
                    repeat (10) tick();
                    checkOutput("no_result_after_abort", resultsSeen - start, 0);
                    return;
                end
                if (gaps && $urandom_range(0, 3) == 0) begin
                    smp_valid = 0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                qv = int'($urandom_range(0, 200)) - 100;
                iv = flags[k] ? qv + int'($urandom_range(1, 100)) : qv - int'($urandom_range(0, 100));
                smp_i = iv[DW-1:0]; smp_q = qv[DW-1:0]; smp_valid = 1;
                if (rewriteThr && k == 50) begin
                    tbl_wr_en = 1; tbl_wr_qid = qid; tbl_wr_sel = 2'd2;
                    tbl_wr_data = (nOnes >= int'(mThr[qid[1:0]])) ? 16'd511 : 16'd0;
                    mThr[qid[1:0]] = tbl_wr_data[CW-1:0];
                end
                n = 0; ok = 0;
                while (!ok && n < 50) begin
                    @(negedge clk); ok = smp_ready; tick(); tbl_wr_en = 0; n++;
                end
                if (!ok) begin
                    failNow("sample_handshake_timeout");
                    break;
                end
            end
            smp_valid = 0;
        end
        n = 0;
        while (resultsSeen == start && n < 40) begin
            tick(); n++;
        end
        checkOutput("result_arrived", resultsSeen - start, 1);
        noFinish = 0;
    endtask

    // Hold a request for an invalid qid high so handshakes follow each REPORT back-to-back.
    task automatic applyBurst(input int count);
        exp_t e;
        int   start, hs, n;
        bit   ok;
        start = resultsSeen;
        for (int i = 0; i < count; i++) begin
            e.qid = 3'd6; e.state = 0; e.count = '0; e.err = 1;
            e.nValid = 0; e.nStart = 0; e.chkLat = 1;
            expQ.push_back(e);
        end
        req_qid = 3'd6; req_valid = 1; hs = 0; n = 0;
        while (hs < count && n < 40) begin
            @(negedge clk); ok = req_ready; tick(); n++;
            if (ok) hs++;
        end
        req_valid = 0;
        n = 0;
        while (resultsSeen - start < count && n < 20) begin
            tick(); n++;
        end
        checkOutput("burst_results", resultsSeen - start, count);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nOnes;
        logic [QW-1:0] qid;
        for (int i = 0; i < NQ; i++) begin
            mInt[i] = '0; mSlope[i] = '0; mThr[i] = '0;
        end
        smp_i = 16'h1234; smp_q = 16'h5678;
        repeat (3) tick();
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_smp_ready", smp_ready, 0);
        checkOutput("rst_coeff_wr_en", cls_coeff_wr_en, 0);
        checkOutput("rst_coeff_addr", cls_coeff_wr_addr, 0);
        checkOutput("rst_coeff_data", cls_coeff_wr_data, 0);
        checkOutput("rst_start", cls_start_count, 0);
        checkOutput("rst_finish", cls_finish_count, 0);
        checkOutput("rst_cls_valid", cls_valid, 0);
        checkOutput("rst_cls_i", cls_i, 0);
        checkOutput("rst_cls_q", cls_q, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_qid", res_qid, 0);
        checkOutput("rst_res_state", res_state, 0);
        checkOutput("rst_res_count", res_count, 0);
        checkOutput("rst_res_err", res_err, 0);
        smp_i = '0; smp_q = '0;
        rst_n = 1;
        repeat (2) tick();

        $display("[TB] default table readback on qid 1");
        applyStimulus(3'd1, int'($urandom_range(0, NS)), 0, 0, 0, 0);

        $display("[TB] qid 2 with 200 ones, threshold 128");
        writeTable(3'd2, 2'd0, 16'h0100);
        writeTable(3'd2, 2'd1, 16'h4000);
        writeTable(3'd2, 2'd2, 16'd128);
        writeTable(3'd2, 2'd3, 16'hBEEF);
        applyStimulus(3'd2, 200, 0, 0, 0, 0);

        $display("[TB] qid 2 with 100 ones and sample gaps");
        applyStimulus(3'd2, 100, 1, 0, 0, 0);

        $display("[TB] invalid qid 5");
        applyStimulus(3'd5, 0, 0, 0, 0, 0);

        $display("[TB] drain timeout on qid 3, threshold above window");
        writeTable(3'd3, 2'd2, 16'd300);
        applyStimulus(3'd3, 250, 1, 1, 0, 0);

        $display("[TB] full window of ones, threshold equal to window");
        writeTable(3'd0, 2'd2, 16'd256);
        applyStimulus(3'd0, NS, 0, 0, 0, 0);

        $display("[TB] reset mid-stream, then a normal request");
        writeTable(3'd2, 2'd2, 16'd10);
        applyStimulus(3'd2, 50, 1, 0, 1, 0);
        writeTable(3'd2, 2'd0, 16'h7F00);
        writeTable(3'd2, 2'd2, 16'd60);
        applyStimulus(3'd2, 60, 1, 0, 0, 1);

        $display("[TB] back-to-back requests");
        applyBurst(3);

        $display("[TB] random measurements");
        for (int r = 0; r < 4; r++) begin
            qid = QW'($urandom_range(0, NQ - 1));
            writeTable(qid, 2'd0, DW'($urandom));
            writeTable(qid, 2'd1, DW'($urandom));
            writeTable(qid, 2'd2, DW'($urandom_range(0, 300)));
            nOnes = int'($urandom_range(0, NS));
            applyStimulus(qid, nOnes, bit'($urandom_range(0, 1)), 0, 0, bit'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        checkOutput("pending_results", expQ.size(), 0);
        checkOutput("pending_coeff_writes", coefQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/readout_rx_classifier_ctrl.md
Name: readout_rx_classifier_ctrl

Overview:
- Time-multiplexes one linear-boundary bin classifier across NUM_QUBITS qubits on the readout RX path.
- Holds a per-qubit table of {y_intercept, slope, threshold}.
- On a measurement request it programs the classifier coefficients, frames the IQ sample window with start/finish markers, and counts samples the classifier flags as |1>.
- It then reports a thresholded single-shot state per qubit.

Parameters:
- DATA_WIDTH, 16, IQ sample and coefficient width; must match the classifier.
- NUM_QUBITS, 4, qubits sharing the classifier.
- QID_WIDTH, 2, qubit id width; must satisfy 2^QID_WIDTH >= NUM_QUBITS.
- NUM_SAMPLES, 256, IQ samples per measurement window; must be >= 1.
- COUNT_WIDTH, 9, counter width; must satisfy 2^COUNT_WIDTH > NUM_SAMPLES.
- DRAIN_TIMEOUT, 4, cycles to wait for the classifier finish marker.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tbl_wr_en  in  1  host table write strobe
- tbl_wr_qid  in  QID_WIDTH  qubit entry written
- tbl_wr_sel  in  2  field select: 0 y_intercept, 1 slope, 2 threshold, 3 ignored
- tbl_wr_data  in  DATA_WIDTH  write data; threshold uses the low COUNT_WIDTH bits
- req_valid  in  1  measurement request
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- req_qid  in  QID_WIDTH  qubit to measure
- smp_valid  in  1  upstream IQ sample valid
- smp_ready  out  1  sample accepted when smp_valid and smp_ready are both high
- smp_i, smp_q  in  DATA_WIDTH each  signed IQ sample
- cls_coeff_wr_en  out  1  classifier coefficient write strobe
- cls_coeff_wr_addr  out  1  0 = y_intercept, 1 = slope
- cls_coeff_wr_data  out  DATA_WIDTH  coefficient value
- cls_start_count  out  1  classifier start_count_in
- cls_finish_count  out  1  classifier finish_count_in
- cls_valid  out  1  classifier valid_in
- cls_i, cls_q  out  DATA_WIDTH each  classifier i_in / q_in
- cls_valid_out  in  1  classifier valid_out
- cls_finish_out  in  1  classifier finish_count_out
- cls_count_condition  in  1  classifier |1> decision
- res_valid  out  1  one-cycle result strobe
- res_qid  out  QID_WIDTH  measured qubit
- res_state  out  1  1 when count >= threshold
- res_count  out  COUNT_WIDTH  number of |1> decisions
- res_err  out  1  invalid qubit id or drain timeout

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; all table entries and counters clear to 0; every output is 0 except req_ready = 1.
- Table writes are accepted in any state and take effect next cycle.
- The active measurement uses a copy of its threshold captured in LOAD_INT. Later writes to the same entry do not affect the measurement in flight.
- FSM states and transitions:
  - IDLE: req_ready = 1. On handshake, latch qid, clear sample count and ones count.
    - qid >= NUM_QUBITS: go to REPORT with res_err = 1 and count 0.
    - Otherwise: go to LOAD_INT.
  - LOAD_INT: cls_coeff_wr_en = 1, addr 0, data = table y_intercept. Go to LOAD_SLOPE.
  - LOAD_SLOPE: cls_coeff_wr_en = 1, addr 1, data = table slope. Go to START.
  - START: cls_start_count = 1 for exactly one cycle. Go to STREAM.
  - STREAM: smp_ready = 1.
    - cls_valid = smp_valid; cls_i and cls_q are combinational passthrough of smp_i and smp_q.
    - Gaps in smp_valid stall the window; the sample count advances only on a handshake.
    - On the handshake of sample NUM_SAMPLES, cls_finish_count = 1 in the same cycle. Go to DRAIN.
  - DRAIN: wait for cls_valid_out and cls_finish_out both high; that cycle's decision is counted, then go to REPORT.
    - If DRAIN_TIMEOUT cycles pass without it, go to REPORT with res_err = 1.
  - REPORT: res_valid = 1 for one cycle with res_qid, res_state, res_count, res_err. Go to IDLE.
    - res_* fields hold their values until the next REPORT.
- Counting: in STREAM and DRAIN, ones count increments when cls_valid_out and cls_count_condition are both high.
  - The count saturates at 2^COUNT_WIDTH-1.
  - cls_valid_out is ignored in all other states.
- Classifier latency is 2 cycles, so decisions for the last samples arrive during DRAIN.
- res_state is an unsigned compare of count against threshold.
  - threshold = 0 always yields res_state = 1.
  - threshold > NUM_SAMPLES always yields res_state = 0.
- A request arriving in any state other than IDLE is not accepted (req_ready = 0); no queueing.
- rst_n asserted mid-measurement aborts it with no REPORT.
  - The classifier's own synchronous reset is the inverted rst_n, synchronised at the top level.

Decomposition:
- Shared package readout_rx_pkg holds:
  - FSM state enum (IDLE, LOAD_INT, LOAD_SLOPE, START, STREAM, DRAIN, REPORT);
  - table field select constants (SEL_INTERCEPT = 0, SEL_SLOPE = 1, SEL_THRESHOLD = 2);
  - classifier coefficient address constants.
- Sub-module readout_rx_coeff_table: NUM_QUBITS x {intercept, slope, threshold} register file, with async-reset write port and combinational read by qid.

Test Plan:
- Reset release -> req_ready = 1 and all other outputs 0; table readback through a measurement gives intercept = 0, slope = 0.
- Write qid 2 with intercept 0x0100, slope 0x4000, threshold 128; request qid 2 -> cls_coeff_wr_en high for 2 cycles with (addr 0, 0x0100) then (addr 1, 0x4000); start pulse the next cycle.
- Stream 256 samples with a classifier model forcing count_condition = 1 on 200 -> one res_valid with qid 2, count 200, state 1, err 0; cls_finish_count coincides with the 256th handshake.
- Same stimulus with 100 ones; insert random smp_valid gaps -> count 100, state 0, and exactly 256 cls_valid pulses.
- Request qid 5 with NUM_QUBITS = 4 (QID_WIDTH = 3) -> REPORT 1 cycle after the handshake with err 1, count 0, and no classifier activity.
- Classifier model never raises finish -> err 1 after 4 DRAIN cycles.
- Deassert rst_n mid-STREAM -> immediate IDLE, no res_valid; a new request then completes normally.
- Back-to-back requests: req_ready stays 0 until the cycle after REPORT.
